// File: rtl/rs_station_param.sv
// Reservation station holding dispatched ops in age order (index 0 = oldest). Operands wake from
// the CDB, and the oldest fully-ready op is issued over a valid/ready handshake.
module rs_station_param #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned FUNC_W  = 4,
  parameter int unsigned RD_W    = 4
) (
  input  logic                           clk1,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [FUNC_W-1:0]              disp_func,
  input  logic [RD_W-1:0]                disp_rd,
  input  logic [TAG_W-1:0]               disp_rob,
  input  logic                           disp_s1_rdy,
  input  logic [DATA_W-1:0]              disp_s1_val,
  input  logic [TAG_W-1:0]               disp_s1_tag,
  input  logic                           disp_s2_rdy,
  input  logic [DATA_W-1:0]              disp_s2_val,
  input  logic [TAG_W-1:0]               disp_s2_tag,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  input  logic [DATA_W-1:0]              cdb_data,
  output logic                           iss_valid,
  input  logic                           iss_ready,
  output logic [FUNC_W-1:0]              iss_func,
  output logic [RD_W-1:0]                iss_rd,
  output logic [TAG_W-1:0]               iss_rob,
  output logic [DATA_W-1:0]              iss_s1,
  output logic [DATA_W-1:0]              iss_s2,
  output logic [$clog2(ENTRIES+1)-1:0]   occupancy
);

  localparam int unsigned OCC_W = $clog2(ENTRIES + 1);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic              valid;
    logic [FUNC_W-1:0] func;
    logic [RD_W-1:0]   rd;
    logic [TAG_W-1:0]  rob;
    logic              s1_rdy;
    logic [DATA_W-1:0] s1_val;
    logic [TAG_W-1:0]  s1_tag;
    logic              s2_rdy;
    logic [DATA_W-1:0] s2_val;
    logic [TAG_W-1:0]  s2_tag;
  } entry_t;

  entry_t           ent_q [ENTRIES];
  entry_t           ent_d [ENTRIES];
  entry_t           new_ent;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [IDX_W-1:0] sel_idx, wr_idx;
  logic             sel_found, iss_fire, disp_fire;

  // Capture a matching CDB broadcast into any operand still waiting on its tag.
  function automatic entry_t snoop(entry_t e, logic cv, logic [TAG_W-1:0] ct,
                                   logic [DATA_W-1:0] cd);
    entry_t r;
    r = e;
    if (e.valid && cv) begin
      if (!e.s1_rdy && (e.s1_tag == ct)) begin
        r.s1_rdy = 1'b1;
        r.s1_val = cd;
      end
      if (!e.s2_rdy && (e.s2_tag == ct)) begin
        r.s2_rdy = 1'b1;
        r.s2_val = cd;
      end
    end
    return r;
  endfunction

  // Scan from the youngest down so the last hit is the oldest ready entry.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign occupancy  = occ_q;
  assign disp_ready = (occ_q != OCC_W'(ENTRIES));
  assign iss_valid  = sel_found && !flush;
  assign iss_fire   = iss_valid && iss_ready;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign wr_idx     = occ_q[IDX_W-1:0] - IDX_W'(iss_fire);

  assign iss_func = sel_found ? ent_q[sel_idx].func   : '0;
  assign iss_rd   = sel_found ? ent_q[sel_idx].rd     : '0;
  assign iss_rob  = sel_found ? ent_q[sel_idx].rob    : '0;
  assign iss_s1   = sel_found ? ent_q[sel_idx].s1_val : '0;
  assign iss_s2   = sel_found ? ent_q[sel_idx].s2_val : '0;

  always_comb begin
    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.func   = disp_func;
    new_ent.rd     = disp_rd;
    new_ent.rob    = disp_rob;
    new_ent.s1_rdy = disp_s1_rdy;
    new_ent.s1_val = disp_s1_rdy ? disp_s1_val : '0;
    new_ent.s1_tag = disp_s1_tag;
    new_ent.s2_rdy = disp_s2_rdy;
    new_ent.s2_val = disp_s2_rdy ? disp_s2_val : '0;
    new_ent.s2_tag = disp_s2_tag;

    occ_d = occ_q;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      ent_d[i] = '0;
    end

    if (!flush) begin
      // Compact over the issued slot while applying wakeups to the moved entries.
      for (int i = 0; i < int'(ENTRIES) - 1; i++) begin
        ent_d[i] = snoop((iss_fire && (i >= int'(sel_idx))) ? ent_q[i+1] : ent_q[i],
                         cdb_valid, cdb_tag, cdb_data);
      end
      ent_d[ENTRIES-1] = iss_fire ? '0 :
                         snoop(ent_q[ENTRIES-1], cdb_valid, cdb_tag, cdb_data);
      if (disp_fire) begin
        ent_d[wr_idx] = snoop(new_ent, cdb_valid, cdb_tag, cdb_data);
      end
      occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(iss_fire);
    end else begin
      occ_d = '0;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ent_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ent_q[i] <= ent_d[i];
      end
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_rs_station_param.sv
// Bench for rs_station_param: scenario tasks drive stimulus; issued ops are checked against a
// queue of expected issue packets filled by the scenarios.
module tb_rs_station_param;

  logic        clk1 = 1'b0;
  logic        rst, flush, disp_valid, disp_ready;
  logic [3:0]  disp_func, disp_rd;
  logic [2:0]  disp_rob, disp_s1_tag, disp_s2_tag, cdb_tag;
  logic        disp_s1_rdy, disp_s2_rdy, cdb_valid;
  logic [15:0] disp_s1_val, disp_s2_val, cdb_data;
  logic        iss_valid, iss_ready;
  logic [3:0]  iss_func, iss_rd;
  logic [2:0]  iss_rob;
  logic [15:0] iss_s1, iss_s2;
  logic [2:0]  occupancy;

  typedef struct packed {
    logic [3:0]  func;
    logic [3:0]  rd;
    logic [2:0]  rob;
    logic [15:0] s1;
    logic [15:0] s2;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  rs_station_param #(
    .ENTRIES(4), .DATA_W(16), .TAG_W(3), .FUNC_W(4), .RD_W(4)
  ) dut (
    .clk1(clk1), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_func(disp_func), .disp_rd(disp_rd), .disp_rob(disp_rob),
    .disp_s1_rdy(disp_s1_rdy), .disp_s1_val(disp_s1_val), .disp_s1_tag(disp_s1_tag),
    .disp_s2_rdy(disp_s2_rdy), .disp_s2_val(disp_s2_val), .disp_s2_tag(disp_s2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_func(iss_func), .iss_rd(iss_rd), .iss_rob(iss_rob),
    .iss_s1(iss_s1), .iss_s2(iss_s2), .occupancy(occupancy)
  );

  always #5 clk1 = ~clk1;

  // Issue monitor: a fire happens at the next posedge, so compare mid-cycle.
  always begin
    exp_t e, got;
    @(negedge clk1);
    #2;
    if (iss_valid && iss_ready && !rst) begin
      got = '{func: iss_func, rd: iss_rd, rob: iss_rob, s1: iss_s1, s2: iss_s2};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got %h, required no issue", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL issue_pkt: got %h, required %h", got, e);
        end
      end
    end
  end

  task automatic idle();
    flush = 0; disp_valid = 0; cdb_valid = 0; iss_ready = 0;
    disp_func = 0; disp_rd = 0; disp_rob = 0;
    disp_s1_rdy = 0; disp_s1_val = 0; disp_s1_tag = 0;
    disp_s2_rdy = 0; disp_s2_val = 0; disp_s2_tag = 0;
    cdb_tag = 0; cdb_data = 0;
  endtask

  task automatic set_disp(input logic [3:0] f, input logic [3:0] rd, input logic [2:0] rob,
                          input logic r1, input logic [15:0] v1, input logic [2:0] t1,
                          input logic r2, input logic [15:0] v2, input logic [2:0] t2);
    disp_valid = 1; disp_func = f; disp_rd = rd; disp_rob = rob;
    disp_s1_rdy = r1; disp_s1_val = v1; disp_s1_tag = t1;
    disp_s2_rdy = r2; disp_s2_val = v2; disp_s2_tag = t2;
  endtask

  task automatic set_cdb(input logic [2:0] t, input logic [15:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    #12;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ: got %0d, required 0", occupancy); end
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL reset_dready: got %b, required 1", disp_ready); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL reset_ivalid: got %b, required 0", iss_valid); end
    total++;
    if ({iss_func, iss_rd, iss_rob, iss_s1, iss_s2} !== '0) begin
      bad++; $display("FAIL reset_idata: got %h, required 0", {iss_func, iss_rd, iss_rob, iss_s1, iss_s2});
    end
    rst = 0;
  endtask

  task automatic test_basic_issue();
    @(negedge clk1); idle(); set_disp(4'h1, 4'h1, 3'd0, 1, 16'd5, 0, 1, 16'd7, 0);
    @(negedge clk1); idle();
    exp_q.push_back('{func: 4'h1, rd: 4'h1, rob: 3'd0, s1: 16'd5, s2: 16'd7});
    iss_ready = 1;
    #3;
    total++; if (iss_valid !== 1'b1) begin bad++; $display("FAIL basic_ivalid: got %b, required 1", iss_valid); end
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL basic_occ1: got %0d, required 1", occupancy); end
    @(negedge clk1); idle(); #3;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL basic_occ0: got %0d, required 0", occupancy); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL basic_idle: got %b, required 0", iss_valid); end
  endtask

  task automatic test_out_of_order();
    @(negedge clk1); idle(); set_disp(4'h2, 4'h2, 3'd1, 1, 16'h0011, 0, 0, 16'h0, 3'd3);
    @(negedge clk1); idle(); set_disp(4'h3, 4'h3, 3'd2, 1, 16'h0022, 0, 1, 16'h0044, 0);
    @(negedge clk1); idle();
    exp_q.push_back('{func: 4'h3, rd: 4'h3, rob: 3'd2, s1: 16'h0022, s2: 16'h0044});
    iss_ready = 1; #3;
    total++; if (iss_rob !== 3'd2) begin bad++; $display("FAIL ooo_first: got rob %0d, required 2", iss_rob); end
    @(negedge clk1); idle(); set_cdb(3'd3, 16'h00AA); iss_ready = 1; #3;
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL ooo_no_bypass: got %b, required 0", iss_valid); end
    @(negedge clk1); idle();
    exp_q.push_back('{func: 4'h2, rd: 4'h2, rob: 3'd1, s1: 16'h0011, s2: 16'h00AA});
    iss_ready = 1; #3;
    total++; if (iss_s2 !== 16'h00AA) begin bad++; $display("FAIL ooo_wake_s2: got %h, required 00aa", iss_s2); end
    @(negedge clk1); idle(); #3;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL ooo_occ: got %0d, required 0", occupancy); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk1); idle();
      set_disp(4'h4, 4'(i), 3'(i), 1, 16'(16'h100 + i), 0, 0, 16'h0, 3'(4 + i));
    end
    @(negedge clk1); idle(); #3;
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_dready: got %b, required 0", disp_ready); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ: got %0d, required 4", occupancy); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL full_ivalid: got %b, required 0", iss_valid); end
    @(negedge clk1); idle(); set_disp(4'hF, 4'hF, 3'd7, 1, 16'hDEAD, 0, 1, 16'hBEEF, 0);
    @(negedge clk1); idle(); set_cdb(3'd6, 16'h0066); #3;
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_extra_ignored: got %0d, required 4", occupancy); end
    @(negedge clk1); idle();
    exp_q.push_back('{func: 4'h4, rd: 4'd2, rob: 3'd2, s1: 16'h102, s2: 16'h0066});
    iss_ready = 1; #3;
    total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_no_bypass: got %b, required 0", disp_ready); end
    @(negedge clk1); idle(); set_cdb(3'd4, 16'h0044); #3;
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL full_dready_after: got %b, required 1", disp_ready); end
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL full_occ3: got %0d, required 3", occupancy); end
    @(negedge clk1); idle(); set_cdb(3'd5, 16'h0055);
    @(negedge clk1); idle(); set_cdb(3'd7, 16'h0077);
    @(negedge clk1); idle();
    exp_q.push_back('{func: 4'h4, rd: 4'd0, rob: 3'd0, s1: 16'h100, s2: 16'h0044});
    exp_q.push_back('{func: 4'h4, rd: 4'd1, rob: 3'd1, s1: 16'h101, s2: 16'h0055});
    exp_q.push_back('{func: 4'h4, rd: 4'd3, rob: 3'd3, s1: 16'h103, s2: 16'h0077});
    iss_ready = 1;
    @(negedge clk1); iss_ready = 1;
    @(negedge clk1); iss_ready = 1;
    @(negedge clk1); idle(); #3;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL full_drain: got %0d, required 0", occupancy); end
  endtask

  task automatic test_disp_capture();
    @(negedge clk1); idle();
    set_disp(4'h5, 4'h5, 3'd4, 0, 16'h0, 3'd5, 1, 16'd3, 0);
    set_cdb(3'd5, 16'd9);
    @(negedge clk1); idle();
    exp_q.push_back('{func: 4'h5, rd: 4'h5, rob: 3'd4, s1: 16'd9, s2: 16'd3});
    iss_ready = 1; #3;
    total++; if (iss_s1 !== 16'd9) begin bad++; $display("FAIL capture_s1: got %0d, required 9", iss_s1); end
    @(negedge clk1); idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk1); idle(); set_disp(4'h6, 4'h6, 3'd0, 1, 16'h0A, 0, 1, 16'h0B, 0);
    @(negedge clk1); idle(); set_disp(4'h7, 4'h7, 3'd1, 1, 16'h1A, 0, 1, 16'h1B, 0);
    @(negedge clk1); idle(); set_disp(4'h8, 4'h8, 3'd2, 1, 16'h2A, 0, 1, 16'h2B, 0);
    exp_q.push_back('{func: 4'h6, rd: 4'h6, rob: 3'd0, s1: 16'h0A, s2: 16'h0B});
    iss_ready = 1; #3;
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL b2b_occ_before: got %0d, required 2", occupancy); end
    @(negedge clk1); idle(); #3;
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL b2b_occ_after: got %0d, required 2", occupancy); end
    total++; if (iss_rob !== 3'd1) begin bad++; $display("FAIL b2b_head: got rob %0d, required 1", iss_rob); end
    @(negedge clk1); idle();
    exp_q.push_back('{func: 4'h7, rd: 4'h7, rob: 3'd1, s1: 16'h1A, s2: 16'h1B});
    exp_q.push_back('{func: 4'h8, rd: 4'h8, rob: 3'd2, s1: 16'h2A, s2: 16'h2B});
    iss_ready = 1;
    @(negedge clk1); iss_ready = 1;
    @(negedge clk1); idle(); #3;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL b2b_drain: got %0d, required 0", occupancy); end
  endtask

  task automatic test_flush_and_rst();
    @(negedge clk1); idle(); set_disp(4'h9, 4'h9, 3'd0, 1, 16'h1, 0, 1, 16'h2, 0);
    @(negedge clk1); idle(); set_disp(4'h9, 4'h9, 3'd1, 0, 16'h0, 3'd7, 1, 16'h2, 0);
    @(negedge clk1); idle(); set_disp(4'h9, 4'h9, 3'd2, 0, 16'h0, 3'd7, 1, 16'h2, 0);
    @(negedge clk1); idle();
    flush = 1; iss_ready = 1; set_disp(4'hA, 4'hA, 3'd3, 1, 16'h5, 0, 1, 16'h6, 0); #3;
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL flush_occ_before: got %0d, required 3", occupancy); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL flush_gate: got %b, required 0", iss_valid); end
    @(negedge clk1); idle(); #3;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL flush_occ: got %0d, required 0", occupancy); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL flush_ivalid: got %b, required 0", iss_valid); end
    @(negedge clk1); idle(); set_disp(4'hB, 4'hB, 3'd4, 1, 16'h7, 0, 1, 16'h8, 0);
    @(negedge clk1); idle(); set_disp(4'hB, 4'hB, 3'd5, 1, 16'h9, 0, 1, 16'hA, 0);
    @(negedge clk1); idle(); #2;
    rst = 1; #1;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ: got %0d, required 0", occupancy); end
    total++; if (iss_valid !== 1'b0) begin bad++; $display("FAIL rst_ivalid: got %b, required 0", iss_valid); end
    total++; if (iss_s1 !== 16'd0) begin bad++; $display("FAIL rst_is1: got %h, required 0", iss_s1); end
    total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL rst_dready: got %b, required 1", disp_ready); end
    rst = 0;
    @(negedge clk1); idle(); set_disp(4'hC, 4'hC, 3'd6, 1, 16'h33, 0, 1, 16'h44, 0);
    @(negedge clk1); idle();
    exp_q.push_back('{func: 4'hC, rd: 4'hC, rob: 3'd6, s1: 16'h33, s2: 16'h44});
    iss_ready = 1; #3;
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL rst_recover: got %0d, required 1", occupancy); end
    @(negedge clk1); idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_issue();
    test_out_of_order();
    test_full();
    test_disp_capture();
    test_back_to_back();
    test_flush_and_rst();
    @(negedge clk1); #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
